// File: rtl/byte_pipe_wb.sv
// Writeback/forwarding pipeline for the 128-bit byte-operation unit: carries results
// through LATENCY stages into the register file and answers operand-forwarding queries.
module byte_pipe_wb #(
  parameter int LATENCY = 4,
  parameter int DW      = 128,
  parameter int AW      = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [10:0]   in_opcode,
  input  logic [AW-1:0] in_rt,
  input  logic [DW-1:0] in_result,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] q_addr,
  output logic          q_hit,
  output logic [DW-1:0] q_data,
  output logic          q_ready,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          wb_illegal,
  output logic          busy,
  output logic [3:0]    inflight
);

  localparam logic [10:0] OP_0 = 11'b01010110100;
  localparam logic [10:0] OP_1 = 11'b01001010011;
  localparam logic [10:0] OP_2 = 11'b00011010011;
  localparam logic [10:0] OP_3 = 11'b00001010011;

  // Stage arrays: index 0 is stage 1 (youngest), index LATENCY-1 is the last stage.
  logic [LATENCY-1:0]         r_vld;
  logic [LATENCY-1:0]         r_ill;
  logic [LATENCY-1:0][AW-1:0] r_rt;
  logic [LATENCY-1:0][DW-1:0] r_data;

  logic          w_illegal;
  logic [DW-1:0] w_in_data;
  logic          w_hit;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic [3:0]    w_count;

  always_comb begin
    w_illegal = !((in_opcode == OP_0) || (in_opcode == OP_1) ||
                  (in_opcode == OP_2) || (in_opcode == OP_3));
    w_in_data = w_illegal ? '0 : in_result;
  end

  // Handshake: in_valid is accepted only on an edge with stall=0 and flush=0; while
  // stall=1 nothing is accepted and the issuer keeps presenting the same instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld      <= '0;
      r_ill      <= '0;
      r_rt       <= '0;
      r_data     <= '0;
      wb_en      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      wb_illegal <= 1'b0;
    end else if (flush) begin
      r_vld <= '0;
      wb_en <= 1'b0;
    end else if (stall) begin
      wb_en <= 1'b0;
    end else begin
      r_vld[0]  <= in_valid;
      r_ill[0]  <= w_illegal;
      r_rt[0]   <= in_rt;
      r_data[0] <= w_in_data;
      for (int k = 1; k < LATENCY; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_ill[k]  <= r_ill[k-1];
        r_rt[k]   <= r_rt[k-1];
        r_data[k] <= r_data[k-1];
      end
      wb_en <= r_vld[LATENCY-1];
      if (r_vld[LATENCY-1]) begin
        wb_addr    <= r_rt[LATENCY-1];
        wb_data    <= r_data[LATENCY-1];
        wb_illegal <= r_ill[LATENCY-1];
      end
    end
  end

  // Scan oldest-to-youngest so the youngest matching stage is the last to overwrite.
  always_comb begin
    w_hit   = 1'b0;
    w_ready = 1'b0;
    w_data  = '0;
    if (wb_en && (wb_addr == q_addr)) begin
      w_hit   = 1'b1;
      w_ready = 1'b1;
      w_data  = wb_data;
    end
    for (int k = LATENCY - 1; k >= 0; k--) begin
      if (r_vld[k] && (r_rt[k] == q_addr)) begin
        w_hit   = 1'b1;
        w_ready = (k != 0);
        w_data  = r_data[k];
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < LATENCY; k++) begin
      w_count = w_count + {3'b000, r_vld[k]};
    end
  end

  assign q_hit    = w_hit;
  assign q_ready  = w_ready;
  assign q_data   = w_data;
  assign inflight = w_count;
  assign busy     = (w_count != 4'd0) | wb_en;

endmodule

// File: tb/tb_byte_pipe_wb.sv
// Bench for byte_pipe_wb: directed vector table, hand-written corner sequences and
// randomized traffic checked against an in-flight-list reference model.
module tb_byte_pipe_wb;

  localparam int LAT = 4;
  localparam int W   = 136;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [10:0]   in_opcode;
  logic [6:0]    in_rt;
  logic [127:0]  in_result;
  logic          stall;
  logic          flush;
  logic [6:0]    q_addr;
  logic          q_hit;
  logic [127:0]  q_data;
  logic          q_ready;
  logic          wb_en;
  logic [6:0]    wb_addr;
  logic [127:0]  wb_data;
  logic          wb_illegal;
  logic          busy;
  logic [3:0]    inflight;

  byte_pipe_wb #(.LATENCY(LAT), .DW(128), .AW(7)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_rt(in_rt), .in_result(in_result), .stall(stall), .flush(flush),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .q_ready(q_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_illegal(wb_illegal),
    .busy(busy), .inflight(inflight)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] legal_ops [4] = '{11'b01010110100, 11'b01001010011,
                                 11'b00011010011, 11'b00001010011};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [7:0] t);
    return {16{t}};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic       ill;
    logic [6:0] rt;
    logic [7:0] tag;
    logic       st;
    logic       fl;
    logic [6:0] qa;
    logic       e_en;
    logic [6:0] e_addr;
    logic       e_ill;
    logic [7:0] e_tag;
    logic [3:0] e_infl;
    logic       e_hit;
    logic       e_rdy;
    logic [7:0] e_qtag;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int v, ill, rt, tag, st, fl, qa,
                              e_en, e_addr, e_ill, e_tag, e_infl, e_hit, e_rdy, e_qtag);
    vec_t r;
    r.v = 1'(v); r.ill = 1'(ill); r.rt = 7'(rt); r.tag = 8'(tag);
    r.st = 1'(st); r.fl = 1'(fl); r.qa = 7'(qa);
    r.e_en = 1'(e_en); r.e_addr = 7'(e_addr); r.e_ill = 1'(e_ill); r.e_tag = 8'(e_tag);
    r.e_infl = 4'(e_infl); r.e_hit = 1'(e_hit); r.e_rdy = 1'(e_rdy); r.e_qtag = 8'(e_qtag);
    return r;
  endfunction

  task automatic fill_table();
    // back-to-back rt=1..6, query rt=3
    tbl.push_back(mk(1,0,1,'h11,0,0,3, 0,0,0,0,     1, 0,0,0));
    tbl.push_back(mk(1,0,2,'h12,0,0,3, 0,0,0,0,     2, 0,0,0));
    tbl.push_back(mk(1,0,3,'h13,0,0,3, 0,0,0,0,     3, 1,0,'h13));
    tbl.push_back(mk(1,0,4,'h14,0,0,3, 0,0,0,0,     4, 1,1,'h13));
    tbl.push_back(mk(1,0,5,'h15,0,0,3, 1,1,0,'h11,  4, 1,1,'h13));
    tbl.push_back(mk(1,0,6,'h16,0,0,3, 1,2,0,'h12,  4, 1,1,'h13));
    tbl.push_back(mk(0,0,0,0,0,0,3,    1,3,0,'h13,  3, 1,1,'h13));
    tbl.push_back(mk(0,0,0,0,0,0,3,    1,4,0,'h14,  2, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,3,    1,5,0,'h15,  1, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,3,    1,6,0,'h16,  0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,3,    0,0,0,0,     0, 0,0,0));
    // stall for 3 cycles starting at cycle 2; in_valid during stall is ignored
    tbl.push_back(mk(1,0,9,'h29,0,0,9, 0,0,0,0,     1, 1,0,'h29));
    tbl.push_back(mk(0,0,0,0,0,0,9,    0,0,0,0,     1, 1,1,'h29));
    tbl.push_back(mk(1,0,10,'h2A,1,0,9,0,0,0,0,     1, 1,1,'h29));
    tbl.push_back(mk(1,0,10,'h2A,1,0,9,0,0,0,0,     1, 1,1,'h29));
    tbl.push_back(mk(1,0,10,'h2A,1,0,9,0,0,0,0,     1, 1,1,'h29));
    tbl.push_back(mk(0,0,0,0,0,0,9,    0,0,0,0,     1, 1,1,'h29));
    tbl.push_back(mk(0,0,0,0,0,0,9,    0,0,0,0,     1, 1,1,'h29));
    tbl.push_back(mk(0,0,0,0,0,0,9,    1,9,0,'h29,  0, 1,1,'h29));
    tbl.push_back(mk(0,0,0,0,0,0,9,    0,0,0,0,     0, 0,0,0));
    // flush kills rt=3 and rt=4; flush beats a concurrent in_valid
    tbl.push_back(mk(1,0,3,'h33,0,0,4, 0,0,0,0,     1, 0,0,0));
    tbl.push_back(mk(1,0,4,'h34,0,0,4, 0,0,0,0,     2, 1,0,'h34));
    tbl.push_back(mk(1,0,5,'h35,0,1,4, 0,0,0,0,     0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,4,    0,0,0,0,     0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,4,    0,0,0,0,     0, 0,0,0));
    // flush on the cycle the wb register holds an entry: that one writes, stage LATENCY does not
    tbl.push_back(mk(1,0,12,'h4C,0,0,13,0,0,0,0,    1, 0,0,0));
    tbl.push_back(mk(1,0,13,'h4D,0,0,13,0,0,0,0,    2, 1,0,'h4D));
    tbl.push_back(mk(0,0,0,0,0,0,13,   0,0,0,0,     2, 1,1,'h4D));
    tbl.push_back(mk(0,0,0,0,0,0,13,   0,0,0,0,     2, 1,1,'h4D));
    tbl.push_back(mk(0,0,0,0,0,0,13,   1,12,0,'h4C, 1, 1,1,'h4D));
    tbl.push_back(mk(0,0,0,0,0,1,13,   0,0,0,0,     0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,13,   0,0,0,0,     0, 0,0,0));
    // illegal opcode: data forced to zero, still writes back
    tbl.push_back(mk(1,1,2,'h55,0,0,2, 0,0,0,0,     1, 1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,2,    0,0,0,0,     1, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,2,    0,0,0,0,     1, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,2,    0,0,0,0,     1, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,2,    1,2,1,0,     0, 1,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,2,    0,0,0,0,     0, 0,0,0));
    // two in-flight writers of rt=7: youngest forwards, both write in order
    tbl.push_back(mk(1,0,7,'hA1,0,0,7, 0,0,0,0,     1, 1,0,'hA1));
    tbl.push_back(mk(1,0,7,'hB2,0,0,7, 0,0,0,0,     2, 1,0,'hB2));
    tbl.push_back(mk(0,0,0,0,0,0,7,    0,0,0,0,     2, 1,1,'hB2));
    tbl.push_back(mk(0,0,0,0,0,0,8,    0,0,0,0,     2, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,7,    1,7,0,'hA1,  1, 1,1,'hB2));
    tbl.push_back(mk(0,0,0,0,0,0,7,    1,7,0,'hB2,  0, 1,1,'hB2));
    tbl.push_back(mk(0,0,0,0,0,0,7,    0,0,0,0,     0, 0,0,0));
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [6:0]   rt;
    logic [127:0] d;
    logic         ill;
    int           stage;
  } ent_t;

  ent_t         flight_q[$];
  logic [W-1:0] exp_q[$];
  logic         m_wb_en;
  logic [6:0]   m_wb_addr;
  logic [127:0] m_wb_data;
  logic         m_wb_ill;
  logic [W-1:0] m_wb_exp;

  function automatic logic is_legal(input logic [10:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic rst, input logic fl, input logic st, input logic v,
                            input logic [10:0] op, input logic [6:0] rt, input logic [127:0] res);
    ent_t e;
    if (rst) begin
      flight_q.delete(); exp_q.delete();
      m_wb_en = 1'b0; m_wb_addr = '0; m_wb_data = '0; m_wb_ill = 1'b0;
    end else if (fl) begin
      flight_q.delete(); exp_q.delete();
      m_wb_en = 1'b0;
    end else if (st) begin
      m_wb_en = 1'b0;
    end else begin
      foreach (flight_q[i]) flight_q[i].stage++;
      m_wb_en = 1'b0;
      if (flight_q.size() > 0 && flight_q[0].stage > LAT) begin
        e = flight_q.pop_front();
        m_wb_en = 1'b1; m_wb_addr = e.rt; m_wb_data = e.d; m_wb_ill = e.ill;
        if (exp_q.size() == 0) chk("sb_underflow", 128'(1), 128'(0));
        else m_wb_exp = exp_q.pop_front();
      end
      if (v) begin
        e.rt = rt; e.ill = !is_legal(op); e.d = e.ill ? '0 : res; e.stage = 1;
        flight_q.push_back(e);
        exp_q.push_back({e.ill, e.rt, e.d});
      end
    end
  endtask

  task automatic model_check(input int c);
    logic         e_hit, e_rdy;
    logic [127:0] e_qd;
    int           best;
    e_hit = 1'b0; e_rdy = 1'b0; e_qd = '0; best = LAT + 1;
    foreach (flight_q[i]) begin
      if (flight_q[i].rt == q_addr && flight_q[i].stage < best) begin
        best = flight_q[i].stage; e_hit = 1'b1; e_qd = flight_q[i].d;
        e_rdy = (flight_q[i].stage >= 2);
      end
    end
    if (!e_hit && m_wb_en && m_wb_addr == q_addr) begin
      e_hit = 1'b1; e_rdy = 1'b1; e_qd = m_wb_data;
    end
    chk($sformatf("rnd%0d_wb_en", c), 128'(wb_en), 128'(m_wb_en));
    if (m_wb_en) begin
      chk($sformatf("rnd%0d_wb_addr", c), 128'(wb_addr), 128'(m_wb_exp[134:128]));
      chk($sformatf("rnd%0d_wb_data", c), wb_data, m_wb_exp[127:0]);
      chk($sformatf("rnd%0d_wb_ill", c), 128'(wb_illegal), 128'(m_wb_exp[135]));
    end
    chk($sformatf("rnd%0d_inflight", c), 128'(inflight), 128'(flight_q.size()));
    chk($sformatf("rnd%0d_busy", c), 128'(busy), 128'((flight_q.size() != 0) || m_wb_en));
    chk($sformatf("rnd%0d_q_hit", c), 128'(q_hit), 128'(e_hit));
    chk($sformatf("rnd%0d_q_ready", c), 128'(q_ready), 128'(e_rdy));
    chk($sformatf("rnd%0d_q_data", c), q_data, e_qd);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_en"}, 128'(wb_en), 128'(0));
    chk({tag, "_wb_addr"}, 128'(wb_addr), 128'(0));
    chk({tag, "_wb_data"}, wb_data, 128'(0));
    chk({tag, "_wb_ill"}, 128'(wb_illegal), 128'(0));
    chk({tag, "_q_hit"}, 128'(q_hit), 128'(0));
    chk({tag, "_q_data"}, q_data, 128'(0));
    chk({tag, "_q_ready"}, 128'(q_ready), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_inflight"}, 128'(inflight), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_rt = '0; in_result = '0;
    stall = 1'b0; flush = 1'b0; q_addr = '0;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // single op, writeback exactly at cycle 4
    in_valid = 1'b1; in_opcode = 11'b01010110100; in_rt = 7'd5;
    in_result = 128'h0102030405060708090a0b0c0d0e0f10;
    tick();
    in_valid = 1'b0;
    chk("single_c0_wb_en", 128'(wb_en), 128'(0));
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 4) begin
        chk("single_c4_wb_en", 128'(wb_en), 128'(1));
        chk("single_c4_wb_addr", 128'(wb_addr), 128'(5));
        chk("single_c4_wb_data", wb_data, 128'h0102030405060708090a0b0c0d0e0f10);
        chk("single_c4_wb_ill", 128'(wb_illegal), 128'(0));
      end else begin
        chk($sformatf("single_c%0d_wb_en", c), 128'(wb_en), 128'(0));
      end
    end

    // table-driven directed vectors
    fill_table();
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      in_valid = t.v; in_opcode = t.ill ? 11'h7FF : legal_ops[i % 4];
      in_rt = t.rt; in_result = pat(t.tag); stall = t.st; flush = t.fl; q_addr = t.qa;
      tick();
      chk($sformatf("row%0d_wb_en", i), 128'(wb_en), 128'(t.e_en));
      if (t.e_en) begin
        chk($sformatf("row%0d_wb_addr", i), 128'(wb_addr), 128'(t.e_addr));
        chk($sformatf("row%0d_wb_data", i), wb_data, pat(t.e_tag));
        chk($sformatf("row%0d_wb_ill", i), 128'(wb_illegal), 128'(t.e_ill));
      end
      chk($sformatf("row%0d_inflight", i), 128'(inflight), 128'(t.e_infl));
      chk($sformatf("row%0d_busy", i), 128'(busy), 128'((t.e_infl != 0) || t.e_en));
      chk($sformatf("row%0d_q_hit", i), 128'(q_hit), 128'(t.e_hit));
      chk($sformatf("row%0d_q_ready", i), 128'(q_ready), 128'(t.e_rdy));
      chk($sformatf("row%0d_q_data", i), q_data, pat(t.e_qtag));
    end
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;

    // reset mid-operation drops the in-flight entry
    q_addr = 7'd20;
    in_valid = 1'b1; in_opcode = legal_ops[1]; in_rt = 7'd20; in_result = pat(8'h77);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("midreset_after%0d_wb_en", c), 128'(wb_en), 128'(0));
      chk($sformatf("midreset_after%0d_inflight", c), 128'(inflight), 128'(0));
    end

    // randomized traffic against the reference model
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    model_step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int c = 0; c < 2000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      stall     = ($urandom_range(0, 6) == 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      in_opcode = ($urandom_range(0, 3) == 0) ? 11'($urandom) : legal_ops[$urandom_range(0, 3)];
      in_rt     = 7'($urandom_range(0, 7));
      in_result = {$urandom, $urandom, $urandom, $urandom};
      q_addr    = 7'($urandom_range(0, 7));
      tick();
      model_step(reset, flush, stall, in_valid, in_opcode, in_rt, in_result);
      model_check(c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_pipe_wb.md
Name: byte_pipe_wb

Overview:
- Writeback/forwarding pipeline that sits on the result side of the combinational 128-bit byte-operation unit.
- Each cycle it accepts one issued byte-class instruction with its computed 128-bit result and destination register tag.
- It carries the result through a fixed-latency pipeline and writes it into the 128-entry register file at the final stage.
- It also answers operand-forwarding queries from the issue stage and reports hazards for in-flight destinations.

Parameters:
- LATENCY, 4, number of pipeline stages from accept to writeback; legal range 2..8.
- DW, 128, result data width.
- AW, 7, register address width (128 registers).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  issue presents an instruction this cycle
- in_opcode  input  11  byte-class opcode of the issued instruction
- in_rt  input  AW  destination register address
- in_result  input  DW  result from the byte unit for this instruction
- stall  input  1  hold all stages; no writeback while asserted
- flush  input  1  kill every in-flight instruction
- q_addr  input  AW  forwarding query register address
- q_hit  output  1  some valid in-flight stage targets q_addr
- q_data  output  DW  result of the youngest matching stage
- q_ready  output  1  q_hit and the matching entry is at or past stage 2
- wb_en  output  1  register-file write enable
- wb_addr  output  AW  register-file write address
- wb_data  output  DW  register-file write data
- wb_illegal  output  1  written entry carried an unrecognised opcode
- busy  output  1  any stage valid
- inflight  output  4  count of valid stages

Behaviour:
- Reset values (synchronous, active-high): all stage valids 0; wb_en, wb_addr, wb_data, wb_illegal, q_hit, q_data, q_ready, busy and inflight all 0. Reset has priority over flush, stall and in_valid.
- Stage 1 captures {in_valid & ~flush, in_rt, in_result, illegal} on each non-stalled cycle.
  - illegal = 1 unless in_opcode is one of 01010110100, 01001010011, 00011010011, 00001010011.
- Data held for an illegal entry is forced to 0. The entry still writes back.
- Non-stalled cycle: stage k+1 takes stage k for k = 1..LATENCY-1.
- Writeback:
  - wb_en, wb_addr, wb_data and wb_illegal are registered from stage LATENCY.
  - They are valid exactly LATENCY cycles after acceptance, assuming no stalls.
  - wb_en is 1 for exactly one cycle per instruction.
- stall=1:
  - Every stage holds.
  - in_valid is ignored; the issuer must hold it.
  - wb_en is 0 that cycle; wb_addr and wb_data hold their last values.
- flush=1: all stage valids clear next cycle, and wb_en is 0 next cycle. flush takes priority over stall and in_valid.
- Back-to-back accepts every cycle are supported. Two in-flight entries may target the same rt; both write back, in order.
- Forwarding (combinational from stage registers):
  - The scan covers stages 1..LATENCY plus the registered wb stage.
  - The youngest valid match wins; stage 1 is the youngest.
  - q_ready = hit found in stage >= 2 or in the wb stage.
  - If there is no hit, q_data = 0.
  - The issuer stalls on q_hit & ~q_ready.
- inflight = number of valid stages among 1..LATENCY, excluding the wb register. busy = (inflight != 0) | wb_en.
- Simultaneous flush and writeback: the entry that was already in the wb register still writes this cycle; stage LATENCY does not.
- Reset mid-operation drops all in-flight entries with no writeback.

Test Plan:
- Single op: in_valid=1, opcode 01010110100, rt=5, result=128'h0102...10 at cycle 0 -> wb_en=1, wb_addr=5, wb_data equal to input at cycle 4 only; wb_illegal=0.
- Back-to-back: 6 accepts on consecutive cycles, rt=1..6 -> wb_en high for cycles 4..9 with wb_addr 1..6 in order; inflight peaks at 4.
- Stall: accept rt=9, then stall for 3 cycles starting at cycle 2 -> writeback at cycle 7; wb_en=0 during the stall.
- Flush: accept rt=3 and rt=4, flush at cycle 2 -> no wb_en for either; busy=0 by cycle 4.
- Forwarding: rt=7 accepted at cycle 0 with data A and at cycle 1 with data B; q_addr=7 -> at cycle 2 q_hit=1, q_data=B, q_ready=1 (youngest wins). With q_addr=8 -> q_hit=0, q_data=0.
- Illegal opcode and reset: opcode 11'h7FF, rt=2 -> wb at cycle 4 with data 0 and wb_illegal=1. Separately, assert reset at cycle 2 during an in-flight op -> no writeback; all outputs 0.
